// File: rtl/core_irq_ctrl.sv
`timescale 1ns/1ps
// core_irq_ctrl: interrupt controller for a 6502-class core. Synchronises N request
// lines, latches edge requests, masks/enables/prioritises them on the opcode-fetch strobe
// and drives the force-BRK / force-I / vector outputs for the shared BRK microcode.
// Ports:
//   I_clock, I_reset      clock, asynchronous active-high reset
//   I_sync                one-cycle strobe at each opcode fetch
//   I_irq                 raw request lines (CHANNELS wide)
//   I_chan_enable         per-channel selection enable (latching is unaffected)
//   I_irq_mask            CPU P.I flag, blocks maskable channels
//   I_ack                 vector high byte fetched, ends the active sequence
//   O_force_brk           replace fetched opcode with the BRK sequence
//   O_irq_mask            set P.I during the sequence
//   O_vec_addr_lo/hi      vector byte addresses for the active sequence
//   O_chan_id             selected channel
//   O_pending             per-channel pending state
module core_irq_ctrl #(
  parameter int                  CHANNELS    = 2,
  parameter logic [CHANNELS-1:0] EDGE_MASK   = 2'b10,
  parameter logic [CHANNELS-1:0] NMI_MASK    = 2'b10,
  parameter logic [15:0]         VEC_BASE    = 16'hFFFE,
  parameter int                  VEC_STRIDE  = 4,
  parameter logic [15:0]         RESET_VEC   = 16'hFFFC,
  parameter int                  SYNC_STAGES = 2,
  localparam int                 CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                I_clock,
  input  logic                I_reset,
  input  logic                I_sync,
  input  logic [CHANNELS-1:0] I_irq,
  input  logic [CHANNELS-1:0] I_chan_enable,
  input  logic                I_irq_mask,
  input  logic                I_ack,
  output logic                O_force_brk,
  output logic                O_irq_mask,
  output logic [15:0]         O_vec_addr_lo,
  output logic [15:0]         O_vec_addr_hi,
  output logic [CW-1:0]       O_chan_id,
  output logic [CHANNELS-1:0] O_pending
);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_sel;
  logic [CW-1:0]       w_sel_nxt;
  logic [CW-1:0]       w_top;
  logic [CHANNELS-1:0] w_sync;
  logic [CHANNELS-1:0] r_last;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] w_pend_nxt;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] w_pending;
  logic [CHANNELS-1:0] w_elig;

  logic                r_force_brk;
  logic                r_irq_mask;
  logic [15:0]         r_vec_lo;
  logic [15:0]         r_vec_hi;
  logic [CW-1:0]       r_chan_id;
  logic                w_fb_nxt;
  logic [15:0]         w_vec_nxt;
  logic [CW-1:0]       w_id_nxt;

  // Channel i vector lo = VEC_BASE - VEC_STRIDE*i, wrapped to 16 bits.
  function automatic logic [15:0] vec_of(input logic [CW-1:0] s);
    logic [31:0] v;
    v = 32'(VEC_BASE) - 32'(VEC_STRIDE) * 32'(s);
    return v[15:0];
  endfunction

  // Input synchroniser; depth 0 feeds the raw lines straight through.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = I_irq;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
      always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= I_irq;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end
      assign w_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_rise    = w_sync & ~r_last & EDGE_MASK;
  // Level channels bypass the latch entirely; their r_pend bits stay 0.
  assign w_pending = (r_pend & EDGE_MASK) | (w_sync & ~EDGE_MASK);
  assign w_elig    = w_pending & I_chan_enable & (NMI_MASK | ~{CHANNELS{I_irq_mask}});

  always_comb begin
    w_clr = '0;
    if (r_state == ST_SERVICE && I_ack) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (CW'(i) == r_sel) w_clr[i] = 1'b1;
      end
    end
  end

  // A new edge wins over a same-cycle acknowledge so the request is not lost.
  assign w_pend_nxt = ((r_pend & ~w_clr) | w_rise) & EDGE_MASK;

  // Highest eligible index wins.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_elig[i]) w_top = CW'(i);
    end
  end

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      r_last <= '0;
      r_pend <= '0;
    end else begin
      r_last <= w_sync;
      r_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      r_state     <= ST_RESET;
      r_sel       <= '0;
      r_force_brk <= 1'b1;
      r_irq_mask  <= 1'b1;
      r_vec_lo    <= RESET_VEC;
      r_vec_hi    <= RESET_VEC + 16'd1;
      r_chan_id   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_force_brk <= w_fb_nxt;
      r_irq_mask  <= w_fb_nxt;
      r_vec_lo    <= w_vec_nxt;
      r_vec_hi    <= w_vec_nxt + 16'd1;
      r_chan_id   <= w_id_nxt;
    end
  end

  // Next state plus next registered outputs, so outputs change on the same
  // edge that samples I_sync / I_ack.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    case (r_state)
      ST_RESET: begin
        if (I_ack) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (I_sync && (|w_elig)) begin
          w_sel_nxt   = w_top;
          w_state_nxt = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (I_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_RESET;
    endcase

    w_fb_nxt  = (w_state_nxt != ST_IDLE);
    w_vec_nxt = vec_of(w_sel_nxt);
    w_id_nxt  = w_sel_nxt;
    if (w_state_nxt == ST_RESET) begin
      w_vec_nxt = RESET_VEC;
      w_id_nxt  = '0;
    end
  end

  assign O_force_brk   = r_force_brk;
  assign O_irq_mask    = r_irq_mask;
  assign O_vec_addr_lo = r_vec_lo;
  assign O_vec_addr_hi = r_vec_hi;
  assign O_chan_id     = r_chan_id;
  assign O_pending     = w_pending;

endmodule

// File: tb/tb_core_irq_ctrl.sv
`timescale 1ns/1ps
// Bench for core_irq_ctrl with default parameters (2 channels, ch1 edge + NMI).
// Each forced sequence the bench provokes pushes its expected vector/channel; a
// monitor pops and compares when the DUT raises O_force_brk.
module tb_core_irq_ctrl;

  logic        I_clock;
  logic        I_reset;
  logic        I_sync;
  logic [1:0]  I_irq;
  logic [1:0]  I_chan_enable;
  logic        I_irq_mask;
  logic        I_ack;
  logic        O_force_brk;
  logic        O_irq_mask;
  logic [15:0] O_vec_addr_lo;
  logic [15:0] O_vec_addr_hi;
  logic [0:0]  O_chan_id;
  logic [1:0]  O_pending;

  core_irq_ctrl dut (
    .I_clock       (I_clock),
    .I_reset       (I_reset),
    .I_sync        (I_sync),
    .I_irq         (I_irq),
    .I_chan_enable (I_chan_enable),
    .I_irq_mask    (I_irq_mask),
    .I_ack         (I_ack),
    .O_force_brk   (O_force_brk),
    .O_irq_mask    (O_irq_mask),
    .O_vec_addr_lo (O_vec_addr_lo),
    .O_vec_addr_hi (O_vec_addr_hi),
    .O_chan_id     (O_chan_id),
    .O_pending     (O_pending)
  );

  typedef struct packed {
    logic [15:0] lo;
    logic [7:0]  ch;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic seen  = 1'b0;

  initial I_clock = 1'b0;
  always #5 I_clock = ~I_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge I_clock);
    #1;
  endtask

  task automatic pulse_sync();
    I_sync = 1'b1;
    tick(1);
    I_sync = 1'b0;
  endtask

  task automatic pulse_ack();
    I_ack = 1'b1;
    tick(1);
    I_ack = 1'b0;
  endtask

  task automatic expect_seq(input logic [15:0] lo, input logic [7:0] ch);
    exp_t e;
    e.lo = lo;
    e.ch = ch;
    q.push_back(e);
  endtask

  // Scoreboard monitor: one pop per start of a forced sequence.
  always @(negedge I_clock) begin
    if (I_reset || !O_force_brk) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (q.size() == 0) begin
        chk("sb_unexpected_seq", 32'(O_force_brk), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_vec_lo", 32'(O_vec_addr_lo), 32'(e.lo));
        chk("sb_vec_hi", 32'(O_vec_addr_hi), 32'(e.lo + 16'd1));
        chk("sb_chan",   32'(O_chan_id),     32'(e.ch));
        chk("sb_imask",  32'(O_irq_mask),    32'd1);
      end
    end
  end

  initial begin
    I_reset = 1'b1; I_sync = 1'b0; I_irq = 2'b00; I_chan_enable = 2'b11;
    I_irq_mask = 1'b0; I_ack = 1'b0;

    // 1: reset state, I_sync ignored in RESET, ack releases
    expect_seq(16'hFFFC, 8'd0);
    tick(3);
    chk("rst_fb",     32'(O_force_brk),   32'd1);
    chk("rst_imask",  32'(O_irq_mask),    32'd1);
    chk("rst_lo",     32'(O_vec_addr_lo), 32'hFFFC);
    chk("rst_hi",     32'(O_vec_addr_hi), 32'hFFFD);
    chk("rst_pend",   32'(O_pending),     32'd0);
    I_reset = 1'b0;
    tick(1);
    pulse_sync();
    chk("rst_sync_ign", 32'(O_force_brk), 32'd1);
    pulse_ack();
    chk("idle_fb",    32'(O_force_brk),   32'd0);
    chk("idle_imask", 32'(O_irq_mask),    32'd0);
    chk("idle_lo",    32'(O_vec_addr_lo), 32'hFFFE);
    chk("idle_hi",    32'(O_vec_addr_hi), 32'hFFFF);

    // 2: maskable level channel blocked by I flag, then served
    I_irq_mask = 1'b1;
    I_irq = 2'b01;
    tick(4);
    chk("t2_pend", 32'(O_pending), 32'b01);
    pulse_sync();
    chk("t2_masked", 32'(O_force_brk), 32'd0);
    I_irq_mask = 1'b0;
    expect_seq(16'hFFFE, 8'd0);
    pulse_sync();
    chk("t2_fb", 32'(O_force_brk), 32'd1);
    I_irq = 2'b00;
    pulse_ack();
    chk("t2_ack_fb", 32'(O_force_brk), 32'd0);
    tick(4);
    chk("t2_pend_gone", 32'(O_pending), 32'd0);

    // 3: one-cycle edge pulse on NMI channel, latency SYNC_STAGES+1
    I_irq_mask = 1'b1;
    I_irq = 2'b10;
    tick(1);
    I_irq = 2'b00;
    tick(1);
    chk("t3_pend_early", 32'(O_pending), 32'b00);
    tick(1);
    chk("t3_pend_set", 32'(O_pending), 32'b10);
    tick(2);
    chk("t3_pend_held", 32'(O_pending), 32'b10);
    expect_seq(16'hFFFA, 8'd1);
    pulse_sync();
    pulse_ack();
    chk("t3_pend_clr", 32'(O_pending), 32'b00);
    chk("t3_fb", 32'(O_force_brk), 32'd0);

    // 4: both pending, highest priority first
    I_irq_mask = 1'b0;
    I_irq = 2'b11;
    tick(4);
    I_irq = 2'b01;
    tick(1);
    chk("t4_pend", 32'(O_pending), 32'b11);
    expect_seq(16'hFFFA, 8'd1);
    pulse_sync();
    pulse_ack();
    chk("t4_pend_after1", 32'(O_pending), 32'b01);
    expect_seq(16'hFFFE, 8'd0);
    pulse_sync();
    I_irq = 2'b00;
    pulse_ack();
    tick(4);

    // 4b: channel enable steers selection while ch1 stays latched
    I_irq = 2'b11;
    tick(1);
    I_irq = 2'b01;
    I_chan_enable = 2'b01;
    tick(4);
    expect_seq(16'hFFFE, 8'd0);
    pulse_sync();
    I_irq = 2'b00;
    pulse_ack();
    tick(4);
    chk("t4b_pend", 32'(O_pending), 32'b10);
    I_chan_enable = 2'b11;
    expect_seq(16'hFFFA, 8'd1);
    pulse_sync();
    pulse_ack();
    chk("t4b_pend_clr", 32'(O_pending), 32'b00);

    // 5: new edge in the same cycle as the acknowledge keeps pending
    I_irq = 2'b10;
    tick(1);
    I_irq = 2'b00;
    tick(4);
    expect_seq(16'hFFFA, 8'd1);
    pulse_sync();
    I_irq = 2'b10;
    tick(1);
    I_irq = 2'b00;
    tick(1);
    pulse_ack();
    chk("t5_pend_kept", 32'(O_pending), 32'b10);
    chk("t5_fb_low", 32'(O_force_brk), 32'd0);
    expect_seq(16'hFFFA, 8'd1);
    pulse_sync();
    chk("t5_reenter", 32'(O_force_brk), 32'd1);
    chk("t5_chan", 32'(O_chan_id), 32'd1);

    // 6: asynchronous reset mid-service
    expect_seq(16'hFFFC, 8'd0);
    tick(1);
    #2;
    I_reset = 1'b1;
    #1;
    chk("t6_fb",   32'(O_force_brk),   32'd1);
    chk("t6_pend", 32'(O_pending),     32'd0);
    chk("t6_lo",   32'(O_vec_addr_lo), 32'hFFFC);
    chk("t6_hi",   32'(O_vec_addr_hi), 32'hFFFD);
    chk("t6_chan", 32'(O_chan_id),     32'd0);
    tick(2);
    I_reset = 1'b0;
    tick(1);
    pulse_ack();
    chk("t6_idle_fb", 32'(O_force_brk),   32'd0);
    chk("t6_idle_lo", 32'(O_vec_addr_lo), 32'hFFFE);

    tick(2);
    chk("sb_left", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
